// File: rtl/flappy_bird_pio_bank.sv
// flappy_bird_pio_bank: Avalon-MM output-port bank with frame-synchronous commit.
//
// Each of NUM_CH channels has a CPU-writable shadow register. The shadows are
// copied to the live outputs together on a frame-sync rising edge, but only when
// something is pending, or on a forced commit. Immediate mode writes go straight
// through to the live outputs.
//
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   address       - word address: 0..NUM_CH-1 channels, NUM_CH ctrl/status, NUM_CH+1 count
//   chipselect    - slave select
//   write_n       - active-low write strobe
//   writedata     - write data (channel writes use the low DATA_W bits)
//   readdata      - combinational read data, zero wait states
//   frame_sync    - video timing level; its rising edge marks a frame boundary
//   out_port      - live channel values, channel k at [k*DATA_W +: DATA_W]
//   commit_pulse  - one-cycle strobe when the live outputs are updated by a commit
module flappy_bird_pio_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     commit_pulse
);

    localparam logic [ADDR_W-1:0] AddrCtrl  = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] AddrCount = ADDR_W'(NUM_CH + 1);

    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] live_q   [NUM_CH];
    logic [DATA_W-1:0] live_d   [NUM_CH];
    logic              pending_q, pending_d;
    logic              imm_mode_q, imm_mode_d;
    logic              commit_pulse_q, commit_pulse_d;
    logic              fs_prev_q;
    logic [15:0]       commit_cnt_q, commit_cnt_d;

    logic wr_en;
    logic ctrl_wr;
    logic force_commit;
    logic fs_rise;
    logic commit;
    logic imm_upd;

    // Only some writedata bits are meaningful; fold the rest into a sink.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en        = chipselect & ~write_n;
    assign ctrl_wr      = wr_en & (address == AddrCtrl);
    assign force_commit = ctrl_wr & writedata[0];
    assign fs_rise      = frame_sync & ~fs_prev_q;
    assign commit       = (fs_rise & pending_q) | force_commit;

    always_comb begin
        shadow_d   = shadow_q;
        live_d     = live_q;
        pending_d  = pending_q;
        imm_mode_d = imm_mode_q;
        imm_upd    = 1'b0;

        // Commit copies the pre-edge shadows; a same-cycle channel write below
        // lands only in the shadow and re-arms pending (set wins over clear).
        if (commit) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en && address == ADDR_W'(k)) begin
                shadow_d[k] = writedata[DATA_W-1:0];
                if (imm_mode_q) begin
                    live_d[k] = writedata[DATA_W-1:0];
                    imm_upd   = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end

        if (ctrl_wr) begin
            imm_mode_d = writedata[1];
        end

        // Commit and immediate update in one cycle still count as one event.
        commit_pulse_d = commit | imm_upd;
        commit_cnt_d   = commit_cnt_q + 16'(commit_pulse_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
                live_q[k]   <= '0;
            end
            pending_q      <= 1'b0;
            imm_mode_q     <= 1'b0;
            commit_pulse_q <= 1'b0;
            fs_prev_q      <= 1'b0;
            commit_cnt_q   <= '0;
        end else begin
            shadow_q       <= shadow_d;
            live_q         <= live_d;
            pending_q      <= pending_d;
            imm_mode_q     <= imm_mode_d;
            commit_pulse_q <= commit_pulse_d;
            fs_prev_q      <= frame_sync;
            commit_cnt_q   <= commit_cnt_d;
        end
    end

    always_comb begin
        readdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_W'(k)) begin
                readdata = 32'(shadow_q[k]);
            end
        end
        if (address == AddrCtrl) begin
            readdata = {30'b0, imm_mode_q, pending_q};
        end
        if (address == AddrCount) begin
            readdata = {16'b0, commit_cnt_q};
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign out_port[k*DATA_W +: DATA_W] = live_q[k];
    end

    assign commit_pulse = commit_pulse_q;

endmodule

// File: doc/flappy_bird_pio_bank.md
Name: flappy_bird_pio_bank

Overview:
Parametrised Avalon-MM output-port bank for the flappy-bird control system. It is the successor to the single 16-bit score output ports. It holds NUM_CH output channels of DATA_W bits, each with a CPU-writable shadow register. Shadows are committed atomically to the live outputs on a frame-sync edge, so the VGA renderer never sees a half-updated score, pipe or bird position set. An immediate-mode bypass and a commit counter are included.

Parameters:
DATA_W, 16, width of each channel (1..32)
NUM_CH, 4, number of output channels (1..8)
ADDR_W, 4, Avalon word-address width; 2^ADDR_W >= NUM_CH+2 required

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  ADDR_W  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
frame_sync  in  1  level from video timing, synchronous to clk; rising edge marks frame boundary
out_port  out  NUM_CH*DATA_W  live channel values, channel k at bits [k*DATA_W +: DATA_W]
commit_pulse  out  1  one-cycle strobe when live outputs change by commit

Behaviour:
- Reset is decided: reset_n, asynchronous, active-low; clock clk. All registers are cleared.
- Reset values: shadow[k]=0, live[k]=0, out_port=0, pending=0, imm_mode=0, commit_cnt=0, commit_pulse=0, frame_sync_d=0.
- Write = chipselect & ~write_n. Only writedata[DATA_W-1:0] is used for channel registers.
- Register map:
  - addr k (0..NUM_CH-1): write sets shadow[k]; read returns shadow[k], zero-extended.
  - addr NUM_CH (CTRL/STATUS): write bit1 sets imm_mode; write bit0=1 forces a commit. Read returns {30'b0, imm_mode, pending}.
  - addr NUM_CH+1 (COUNT): read returns {16'b0, commit_cnt}. Writes are ignored.
  - Any other address reads 0, and writes to it have no effect.
- pending: set by any channel write while imm_mode=0. Cleared by a commit.
- Edge detect: frame_sync_d is registered each cycle. fs_rise = frame_sync & ~frame_sync_d.
- Commit condition, evaluated each cycle: (fs_rise & pending) | (CTRL write with bit0=1).
- On commit at edge N:
  - all live[k] <= shadow[k] as sampled before edge N;
  - pending <= 0;
  - commit_cnt <= commit_cnt+1, wrapping 0xFFFF->0;
  - commit_pulse high for the cycle after edge N.
- Latency: out_port changes one clock after the cycle in which the commit condition is true.
- fs_rise with pending=0: no commit, no pulse, counter unchanged.
- Immediate mode (imm_mode=1):
  - a channel write updates shadow[k] and live[k] on the same edge;
  - commit_pulse fires, commit_cnt increments, pending stays 0.
  - When switching imm_mode from 0 to 1, existing pending shadows stay pending until the next fs_rise or forced commit.
- Simultaneous channel write and commit in the same cycle (non-imm):
  - live takes the old shadow values;
  - the new value lands in shadow;
  - pending ends at 1, because set has priority over clear.
- Forced commit coincident with fs_rise counts as one commit (increment of 1).
- frame_sync held high: only the first cycle is an edge. There are no repeated commits.
- Reset asserted mid-operation clears everything immediately; a pending update is lost.

Test Plan:
- Reset, then read all addresses -> readdata=0 everywhere; out_port=0; commit_pulse=0.
- Write ch0=0x1234, ch3=0xBEEF with frame_sync low -> out_port unchanged (0); STATUS reads 0x1; pulse frame_sync -> one clock after the edge, out_port ch0=0x1234, ch3=0xBEEF; commit_pulse high one cycle; STATUS=0; COUNT=1.
- Write ch1=0x0055 in the same cycle that fs_rise occurs with ch1 previously pending 0x00AA -> live ch1=0x00AA; shadow ch1 reads 0x0055; STATUS=1; next fs_rise gives live ch1=0x0055.
- Write CTRL=0x2 then ch2=0xFFFF_0007 (DATA_W=16) -> ch2 live=0x0007 on the next cycle; commit_pulse asserted; pending=0; COUNT incremented.
- Hold frame_sync high for 10 cycles with pending=1 -> exactly one commit; fs_rise with pending=0 -> no pulse.
- Preload commit_cnt to 0xFFFF via 65535 forced commits (CTRL=0x1), then one more -> COUNT reads 0x0000; assert reset_n low mid-sequence -> all outputs 0 asynchronously.
